// File: rtl/fixed_activation_pipe_if.sv
// Beat-level stream bundle for fixed_activation_pipe: input beat with mode, output beat,
// each side with its own valid/ready handshake.
interface fixed_activation_pipe_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int IN_SIZE   = 4
);
    logic        [1:0]           mode;
    logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE];
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic signed [OUT_WIDTH-1:0] data_out [IN_SIZE];
    logic                        data_out_valid;
    logic                        data_out_ready;

    modport master (
        output mode, data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );

    modport slave (
        input  mode, data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/fixed_activation_pipe.sv
// Two-stage elementwise activation pipeline: S1 applies ReLU/leaky/clip/bypass,
// S2 rescales to the output fixed-point format with half-up rounding and saturation.
module fixed_activation_pipe #(
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 4,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 4,
    parameter int IN_SIZE        = 4,
    parameter int LEAK_SHIFT     = 3,
    parameter int CLIP_VALUE     = 96
) (
    input logic               clk,
    input logic               rst,
    fixed_activation_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_e;

    localparam int D   = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int RSH = (D > 0) ? D : 0;
    localparam int LSH = (D < 0) ? -D : 0;
    // One guard bit above the shifted input keeps the rounding add from overflowing
    localparam int WA  = IN_WIDTH + LSH + 1;
    localparam int WW  = (WA > OUT_WIDTH + 1) ? WA : OUT_WIDTH + 1;

    localparam logic signed [IN_WIDTH-1:0] ZERO_IN = '0;
    localparam logic signed [IN_WIDTH-1:0] CLIP_S  = IN_WIDTH'(CLIP_VALUE);
    localparam logic signed [WW-1:0]       RND     = WW'((2 ** RSH) / 2);
    localparam logic signed [WW-1:0]       MAXV    = WW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WW-1:0]       MINV    = WW'(-(2 ** (OUT_WIDTH - 1)));

    logic                        s1_valid;
    logic                        s2_valid;
    logic signed [IN_WIDTH-1:0]  s1_data   [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] s2_data   [IN_SIZE];
    logic signed [IN_WIDTH-1:0]  act_data  [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] conv_data [IN_SIZE];
    logic                        s1_load;
    logic                        s2_load;

    assign s2_load           = !s2_valid || bus.data_out_ready;
    assign s1_load           = !s1_valid || s2_load;
    assign bus.data_in_ready = s1_load;
    assign bus.data_out_valid = s2_valid;
    assign bus.data_out      = s2_data;

    // Mode is consumed here, so it is bound to the beat as soon as S1 captures it
    always_comb begin
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            act_data[i] = bus.data_in[i];
            case (act_mode_e'(bus.mode))
                ACT_RELU: begin
                    if (bus.data_in[i] <= ZERO_IN) act_data[i] = '0;
                end
                ACT_LEAKY: begin
                    if (bus.data_in[i] < ZERO_IN) act_data[i] = bus.data_in[i] >>> LEAK_SHIFT;
                end
                ACT_CLIP: begin
                    if (bus.data_in[i] <= ZERO_IN)     act_data[i] = '0;
                    else if (bus.data_in[i] > CLIP_S) act_data[i] = CLIP_S;
                end
                default: ;
            endcase
        end
    end

    always_comb begin : conv_blk
        logic signed [WW-1:0] wide;
        wide = '0;
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            wide = WW'(s1_data[i]);
            wide = (wide + RND) >>> RSH;
            wide = wide <<< LSH;
            if (wide > MAXV)      conv_data[i] = OUT_WIDTH'(MAXV);
            else if (wide < MINV) conv_data[i] = OUT_WIDTH'(MINV);
            else                  conv_data[i] = OUT_WIDTH'(wide);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data  <= '{default: '0};
            s2_data  <= '{default: '0};
        end else begin
            if (s1_load) begin
                s1_valid <= bus.data_in_valid;
                if (bus.data_in_valid) s1_data <= act_data;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= conv_data;
            end
        end
    end
endmodule

// File: tb/tb_fixed_activation_pipe.sv
// Directed bench for fixed_activation_pipe: three parameterisations share one input stream,
// plus a stalled stream against a reference model and a mid-stream reset.
module tb_fixed_activation_pipe;
    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic signed [7:0] din [4];
    logic              din_valid;
    logic              dout_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fixed_activation_pipe_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .IN_SIZE(4)) i0 ();
    fixed_activation_pipe_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .IN_SIZE(4)) i1 ();
    fixed_activation_pipe_if #(.IN_WIDTH(8), .OUT_WIDTH(6), .IN_SIZE(4)) i2 ();

    assign i0.mode = mode;  assign i0.data_in = din;  assign i0.data_in_valid = din_valid;  assign i0.data_out_ready = dout_ready;
    assign i1.mode = mode;  assign i1.data_in = din;  assign i1.data_in_valid = din_valid;  assign i1.data_out_ready = dout_ready;
    assign i2.mode = mode;  assign i2.data_in = din;  assign i2.data_in_valid = din_valid;  assign i2.data_out_ready = dout_ready;

    fixed_activation_pipe u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    fixed_activation_pipe #(.OUT_FRAC_WIDTH(2)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    fixed_activation_pipe #(.OUT_WIDTH(6), .OUT_FRAC_WIDTH(4)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk4(input string tag, input int a0, input int a1, input int a2, input int a3,
                        input int e0, input int e1, input int e2, input int e3);
        check({tag, "[0]"}, a0, e0);
        check({tag, "[1]"}, a1, e1);
        check({tag, "[2]"}, a2, e2);
        check({tag, "[3]"}, a3, e3);
    endtask

    // Sends one beat with out_ready high; returns at the negedge where the beat should be visible
    task automatic run_beat(input logic [1:0] m, input int v0, input int v1, input int v2, input int v3);
        @(negedge clk);
        mode = m;
        din[0] = 8'(v0); din[1] = 8'(v1); din[2] = 8'(v2); din[3] = 8'(v3);
        din_valid = 1'b1;
        dout_ready = 1'b1;
        #1 check("beat_in_ready", i0.data_in_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        mode = ~m;
        check("lat1_valid", i0.data_out_valid, 0);
        @(negedge clk);
        check("lat2_valid", i0.data_out_valid, 1);
    endtask

    task automatic finish_beat();
        @(negedge clk);
        check("one_cycle_valid", i0.data_out_valid, 0);
    endtask

    function automatic int ref_act(input int x, input int m);
        case (m)
            0:       return (x > 0) ? x : 0;
            1:       return (x < 0) ? -((-x + 7) / 8) : x;
            2:       return (x <= 0) ? 0 : ((x > 96) ? 96 : x);
            default: return x;
        endcase
    endfunction

    initial begin
        int sent, got, occ;
        int exp_q[$];
        logic stall_prev;
        logic in_x, out_x;
        logic signed [7:0] held [4];

        rst = 1'b0;
        mode = 2'd0;
        din = '{default: '0};
        din_valid = 1'b0;
        dout_ready = 1'b1;
        #3;
        check("rst_valid", i0.data_out_valid, 0);
        check("rst_ready", i0.data_in_ready, 1);
        check("rst_data0", i0.data_out[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_beat(2'd0, -16, 0, 5, 127);
        chk4("relu", i0.data_out[0], i0.data_out[1], i0.data_out[2], i0.data_out[3], 0, 0, 5, 127);
        finish_beat();

        run_beat(2'd1, -16, -3, -128, 40);
        chk4("leaky", i0.data_out[0], i0.data_out[1], i0.data_out[2], i0.data_out[3], -2, -1, -16, 40);
        finish_beat();

        run_beat(2'd1, -1, -8, -9, 0);
        chk4("leaky_edge", i0.data_out[0], i0.data_out[1], i0.data_out[2], i0.data_out[3], -1, -1, -2, 0);
        finish_beat();

        run_beat(2'd2, 100, 96, -5, 50);
        chk4("clip", i0.data_out[0], i0.data_out[1], i0.data_out[2], i0.data_out[3], 96, 96, 0, 50);
        finish_beat();

        run_beat(2'd3, 6, 5, -6, 127);
        chk4("bypass_q44", i0.data_out[0], i0.data_out[1], i0.data_out[2], i0.data_out[3], 6, 5, -6, 127);
        chk4("round_f2", i1.data_out[0], i1.data_out[1], i1.data_out[2], i1.data_out[3], 2, 1, -1, 32);
        finish_beat();

        run_beat(2'd3, 40, -40, 31, -32);
        chk4("sat_w6", i2.data_out[0], i2.data_out[1], i2.data_out[2], i2.data_out[3], 31, -32, 31, -32);
        chk4("round_f2b", i1.data_out[0], i1.data_out[1], i1.data_out[2], i1.data_out[3], 10, -10, 8, -8);
        finish_beat();

        run_beat(2'd3, 2, -2, -128, 1);
        chk4("tie_f2", i1.data_out[0], i1.data_out[1], i1.data_out[2], i1.data_out[3], 1, 0, -32, 0);
        chk4("sat_w6b", i2.data_out[0], i2.data_out[1], i2.data_out[2], i2.data_out[3], 2, -2, -32, 1);
        finish_beat();

        // Stream with random backpressure against the reference model
        sent = 0; got = 0; occ = 0;
        stall_prev = 1'b0;
        held = '{default: '0};
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            if (stall_prev) begin
                check("hold_valid", i0.data_out_valid, 1);
                for (int k = 0; k < 4; k++) check("hold_data", i0.data_out[k], held[k]);
            end
            dout_ready = ($urandom_range(0, 9) >= 3);
            if (sent < 10) begin
                mode = 2'(sent % 4);
                for (int k = 0; k < 4; k++) din[k] = 8'((sent * 29 + k * 53 + 7) % 256 - 128);
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            #1;
            check("stream_in_ready", i0.data_in_ready, (occ == 2 && !dout_ready) ? 0 : 1);
            in_x  = din_valid && i0.data_in_ready;
            out_x = i0.data_out_valid && dout_ready;
            if (out_x) begin
                if (exp_q.size() < 4) begin
                    check("stream_extra_beat", 1, 0);
                end else begin
                    for (int k = 0; k < 4; k++) check("stream_data", i0.data_out[k], exp_q.pop_front());
                end
                got++;
            end
            if (in_x) begin
                for (int k = 0; k < 4; k++) exp_q.push_back(ref_act(int'(din[k]), int'(mode)));
                sent++;
            end
            occ = occ + int'(in_x) - int'(out_x);
            stall_prev = i0.data_out_valid && !dout_ready;
            held = i0.data_out;
        end
        check("stream_count", got, 10);

        // Mid-stream reset with two beats in flight
        @(negedge clk);
        din_valid = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        mode = 2'd3;
        din = '{8'sd11, 8'sd12, 8'sd13, 8'sd14};
        din_valid = 1'b1;
        @(negedge clk);
        din = '{8'sd21, 8'sd22, 8'sd23, 8'sd24};
        @(negedge clk);
        din_valid = 1'b0;
        check("pre_rst_valid", i0.data_out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", i0.data_out_valid, 0);
        check("async_rst_data", i0.data_out[0], 0);
        check("async_rst_ready", i0.data_in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        dout_ready = 1'b1;
        check("post_rst_valid", i0.data_out_valid, 0);
        @(negedge clk);
        check("no_stale_valid", i0.data_out_valid, 0);
        run_beat(2'd0, 3, -3, 7, -7);
        chk4("post_rst", i0.data_out[0], i0.data_out[1], i0.data_out[2], i0.data_out[3], 3, 0, 7, 0);
        finish_beat();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fixed_activation_pipe.md
FIXED_ACTIVATION_PIPE -- requirements
Module: fixed_activation_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: signed input element width.
REQ-002 SHALL have parameter IN_FRAC_WIDTH, default 4: input fractional bits.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: signed output element width.
REQ-004 SHALL have parameter OUT_FRAC_WIDTH, default 4: output fractional bits.
REQ-005 SHALL have parameter IN_SIZE, default 4: elements per beat (channels).
REQ-006 SHALL have parameter LEAK_SHIFT, default 3: leaky slope 2^-LEAK_SHIFT, range 1..IN_WIDTH-1.
REQ-007 SHALL have parameter CLIP_VALUE, default 96: clip ceiling in input format, range 1..2^(IN_WIDTH-1)-1.
REQ-008 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port mode, input, 2: activation select, sampled with each accepted beat.
REQ-011 SHALL have port data_in, input, IN_WIDTH x [IN_SIZE]: unpacked array of input elements.
REQ-012 SHALL have port data_in_valid, input, 1: input beat valid.
REQ-013 SHALL have port data_in_ready, output, 1: block accepts the input beat.
REQ-014 SHALL have port data_out, output, OUT_WIDTH x [IN_SIZE]: unpacked array of output elements.
REQ-015 SHALL have port data_out_valid, output, 1: output beat valid.
REQ-016 SHALL have port data_out_ready, input, 1: downstream accepts the output beat.

Function
REQ-017 Beat transfer SHALL occur only on a cycle where valid and ready are both high, independently on each side.
REQ-018 The block SHALL be a two-stage register pipeline (S1 activation, S2 format conversion), giving a latency of exactly 2 cycles from input transfer to data_out_valid.
REQ-019 S2 SHALL load when S2 is empty or data_out_ready=1; S1 SHALL load when S1 is empty or S2 loads; data_in_ready = S1 may load (combinational, no dependence on data_in_valid).
REQ-020 Under continuous valid and ready, the block SHALL sustain one beat per cycle with no bubbles.
REQ-021 While data_out_valid=1 and data_out_ready=0, data_out and data_out_valid SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-022 Mode 0 (ReLU): element x<=0 -> 0, else x.
REQ-023 Mode 1 (leaky): x<0 -> x arithmetic-shifted right by LEAK_SHIFT (floor), else x.
REQ-024 Mode 2 (clip): x<=0 -> 0; x>CLIP_VALUE -> CLIP_VALUE; else x.
REQ-025 Mode 3 (bypass): x unchanged.
REQ-026 The mode SHALL travel with its beat; a mode change between beats SHALL affect only later beats, including under stall.
REQ-027 S2, for d = IN_FRAC_WIDTH-OUT_FRAC_WIDTH > 0, SHALL round half-up: add 2^(d-1), then arithmetic shift right by d, with no intermediate overflow (one guard bit).
REQ-028 S2, for d < 0, SHALL shift left by -d; for d = 0, value passes unchanged.
REQ-029 S2 SHALL saturate the result to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-030 All channels SHALL be processed identically and independently within a beat.

Reset
REQ-031 rst=0 SHALL asynchronously clear both stage valid flags, so data_out_valid=0 immediately, with data_out=0 and data_in_ready=1 while in reset.
REQ-032 Reset mid-stream SHALL discard in-flight beats; first transfer is allowed the cycle after rst rises, with normal 2-cycle latency.

Verification
REQ-033 Q4.4 defaults, mode 0, data_in={-16,0,5,127}, out_ready=1 -> two cycles later data_out={0,0,5,127}, valid for exactly 1 cycle.
REQ-034 Mode 1, data_in={-16,-3,-128,40} -> data_out={-2,-1,-16,40}; mode 2, {100,96,-5,50} -> {96,96,0,50}.
REQ-035 OUT_FRAC_WIDTH=2, mode 3, data_in={6,5,-6,127} -> {2,1,-1,32}; OUT_WIDTH=6, OUT_FRAC_WIDTH=4, {40,-40,31,-32} -> {31,-32,31,-32}.
REQ-036 Stream 10 beats with alternating modes while data_out_ready follows a random pattern, 30% low -> outputs match a reference model in order, stable under stall, in_ready=0 only when both stages are full and out_ready=0.
REQ-037 Assert rst=0 for 1 cycle with 2 beats in flight -> data_out_valid drops asynchronously; no stale beat emerges; a new beat sent after reset appears 2 cycles after its transfer.
